fetch_sequencer: RTL and testbench

Control FSM that sequences the 16-bit program counter through reset-vector load, instruction fetch, increment and branch load. It sits between `PROGRAM_COUNTER_16` (driving its `load`, `inc` and `data_in16`, reading `data_out16`) and the memory read port. It hands fetched instructions to the execute stage and handles halt/resume and a stuck-memory timeout.

---
 rtl/fetch_sequencer.sv | 175 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Control FSM that walks the 16-bit program counter through reset-vector load,
// instruction fetch, post-fetch increment and branch load. It drives the
// external program counter's load/inc/data_in16 ports, issues reads on the
// memory read port, hands each fetched instruction to the execute stage, and
// supports halt/resume plus a stuck-memory timeout that parks the FSM in FAULT.
//
// Parameters
//   RESET_VECTOR  address loaded into the PC when leaving IDLE
//   ACK_TIMEOUT   WAIT cycles without mem_ack before FAULT (0 disables)
//
// Ports
//   clk, reset_n        single rising-edge clock, async active-low reset
//   run                 start from IDLE / resume from HALT
//   halt_req            go to HALT instead of FETCH when exec_done arrives
//   pc_value            current PC (PC data_out16)
//   pc_load, pc_inc     PC load / increment strobes (never both high)
//   pc_data             PC load value, 0 whenever pc_load is low
//   mem_rd, mem_addr    memory read request and address (FETCH and WAIT only)
//   mem_ack, mem_rdata  read data valid and read data
//   instr, instr_valid  instruction register and its one-cycle "new" pulse
//   exec_done           execute stage finished the current instruction
//   branch_taken        qualifies branch_target on exec_done
//   branch_target       next PC when a branch is taken
//   halted, fault       status flags for HALT and FAULT
//   state               current state encoding, for debug
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        halt_req,
  input  logic [15:0] pc_value,
  output logic        pc_load,
  output logic        pc_inc,
  output logic [15:0] pc_data,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VECTOR = 3'd1,
    S_FETCH  = 3'd2,
    S_WAIT   = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  // The wait counter is 8 bits wide, so only the low byte of the limit matters.
  localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  // NOTE: every signal written below gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    valid_d  = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_data  = 16'h0000;
    mem_rd   = 1'b0;
    mem_addr = 16'h0000;
    halted   = 1'b0;
    fault    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_VECTOR;
      end

      S_VECTOR: begin
        pc_load = 1'b1;
        pc_data = RESET_VECTOR;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc_value;
        cnt_d    = 8'd0;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        mem_rd   = 1'b1;
        mem_addr = pc_value;
        if (mem_ack) begin
          // The PC steps on the same edge the instruction is captured, so it
          // already points at the next instruction while this one executes.
          pc_inc  = 1'b1;
          instr_d = mem_rdata;
          valid_d = 1'b1;
          state_d = S_EXEC;
        end else begin
          // The ack branch is checked first, so an ack landing on the final
          // permitted cycle still wins over the timeout.
          cnt_d = cnt_q + 8'd1;
          if ((ACK_LIMIT != 8'd0) && (cnt_d == ACK_LIMIT)) state_d = S_FAULT;
        end
      end

      S_EXEC: begin
        if (exec_done) begin
          if (branch_taken) begin
            pc_load = 1'b1;
            pc_data = branch_target;
          end
          // A branch load and a halt may coincide: the PC takes the target
          // and resume later fetches from it.
          state_d = halt_req ? S_HALT : S_FETCH;
        end
      end

      S_HALT: begin
        halted = 1'b1;
        if (run) state_d = S_FETCH;
      end

      S_FAULT: begin
        fault = 1'b1;
      end

      default: begin
        // Encoding 7 is never entered; fall back to IDLE if it ever appears.
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      // NOTE: the instruction register is reset too, so a reset mid-fetch
      // never leaves a stale instruction visible to the execute stage.
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Three instances share one clock and reset:
//   u0: RESET_VECTOR=0x0100, ACK_TIMEOUT=255  (fetch/branch/halt sequence table)
//   u1: RESET_VECTOR=0x0100, ACK_TIMEOUT=4    (timeout, ack boundary, reset mid-WAIT)
//   u2: RESET_VECTOR=0x0000, ACK_TIMEOUT=0    (timeout disabled)
// Each instance has its own behavioural program counter and a memory whose
// read data is the bitwise inverse of the address.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  run, halt_req, mem_ack, exec_done, branch_taken;
  logic [15:0] branch_target;

  logic [15:0] pc_value  [3];
  logic        pc_load   [3];
  logic        pc_inc    [3];
  logic [15:0] pc_data   [3];
  logic        mem_rd    [3];
  logic [15:0] mem_addr  [3];
  logic [15:0] mem_rdata [3];
  logic [15:0] instr     [3];
  logic        instr_valid [3];
  logic        halted    [3];
  logic        fault     [3];
  logic [2:0]  state     [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_VECTOR(16'h0100), .ACK_TIMEOUT(255)) u0 (
    .clk(clk), .reset_n(reset_n), .run(run[0]), .halt_req(halt_req[0]),
    .pc_value(pc_value[0]), .pc_load(pc_load[0]), .pc_inc(pc_inc[0]),
    .pc_data(pc_data[0]), .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]),
    .mem_ack(mem_ack[0]), .mem_rdata(mem_rdata[0]), .instr(instr[0]),
    .instr_valid(instr_valid[0]), .exec_done(exec_done[0]),
    .branch_taken(branch_taken[0]), .branch_target(branch_target),
    .halted(halted[0]), .fault(fault[0]), .state(state[0]));

  fetch_sequencer #(.RESET_VECTOR(16'h0100), .ACK_TIMEOUT(4)) u1 (
    .clk(clk), .reset_n(reset_n), .run(run[1]), .halt_req(halt_req[1]),
    .pc_value(pc_value[1]), .pc_load(pc_load[1]), .pc_inc(pc_inc[1]),
    .pc_data(pc_data[1]), .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]),
    .mem_ack(mem_ack[1]), .mem_rdata(mem_rdata[1]), .instr(instr[1]),
    .instr_valid(instr_valid[1]), .exec_done(exec_done[1]),
    .branch_taken(branch_taken[1]), .branch_target(branch_target),
    .halted(halted[1]), .fault(fault[1]), .state(state[1]));

  fetch_sequencer #(.RESET_VECTOR(16'h0000), .ACK_TIMEOUT(0)) u2 (
    .clk(clk), .reset_n(reset_n), .run(run[2]), .halt_req(halt_req[2]),
    .pc_value(pc_value[2]), .pc_load(pc_load[2]), .pc_inc(pc_inc[2]),
    .pc_data(pc_data[2]), .mem_rd(mem_rd[2]), .mem_addr(mem_addr[2]),
    .mem_ack(mem_ack[2]), .mem_rdata(mem_rdata[2]), .instr(instr[2]),
    .instr_valid(instr_valid[2]), .exec_done(exec_done[2]),
    .branch_taken(branch_taken[2]), .branch_target(branch_target),
    .halted(halted[2]), .fault(fault[2]), .state(state[2]));

  // Behavioural program counter and inverse-address memory per instance.
  for (genvar g = 0; g < 3; g++) begin : g_env
    assign mem_rdata[g] = ~mem_addr[g];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        pc_value[g] <= 16'h0000;
      else if (pc_load[g]) pc_value[g] <= pc_data[g];
      else if (pc_inc[g])  pc_value[g] <= pc_value[g] + 16'd1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One table row: inputs for u0 for one cycle, and u0's outputs expected in it.
  typedef struct {
    logic        run, ack, ex, br, hlt;
    logic [15:0] tgt;
    logic [2:0]  st;
    logic        rd;
    logic [15:0] addr;
    logic        ld, inc;
    logic [15:0] pdata;
    logic        iv;
    logic [15:0] ins;
    logic        hl;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] sb[$];

  task automatic add(input logic r, input logic a, input logic e, input logic b,
                     input logic [15:0] t, input logic h, input logic [2:0] st,
                     input logic rd, input logic [15:0] ad, input logic ld,
                     input logic inc, input logic [15:0] pd, input logic iv,
                     input logic [15:0] ins, input logic hl);
    vec_t v;
    v.run = r; v.ack = a; v.ex = e; v.br = b; v.tgt = t; v.hlt = h;
    v.st = st; v.rd = rd; v.addr = ad; v.ld = ld; v.inc = inc; v.pdata = pd;
    v.iv = iv; v.ins = ins; v.hl = hl;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] exp_ins;
    int bad;

    reset_n = 1'b0;
    run = '0; halt_req = '0; mem_ack = '0; exec_done = '0; branch_taken = '0;
    branch_target = 16'h0000;

    //   run ack ex br tgt     hlt | st rd addr    ld inc pdata   iv ins     hl
    add(0, 0, 0, 0, 16'h0,    0,   0, 0, 16'h0,    0, 0, 16'h0,    0, 16'h0,    0); // reset state
    add(1, 0, 0, 0, 16'h0,    0,   0, 0, 16'h0,    0, 0, 16'h0,    0, 16'h0,    0); // run seen in IDLE
    add(0, 0, 0, 0, 16'h0,    0,   1, 0, 16'h0,    1, 0, 16'h0100, 0, 16'h0,    0); // VECTOR load
    add(0, 0, 0, 0, 16'h0,    0,   2, 1, 16'h0100, 0, 0, 16'h0,    0, 16'h0,    0); // FETCH 0100
    add(0, 1, 0, 0, 16'h0,    0,   3, 1, 16'h0100, 0, 1, 16'h0,    0, 16'h0,    0); // WAIT ack
    add(0, 1, 1, 0, 16'h0,    0,   4, 0, 16'h0,    0, 0, 16'h0,    1, 16'hFEFF, 0); // EXEC done
    add(0, 1, 1, 0, 16'h0,    0,   2, 1, 16'h0101, 0, 0, 16'h0,    0, 16'hFEFF, 0); // FETCH 0101
    add(0, 1, 1, 0, 16'h0,    0,   3, 1, 16'h0101, 0, 1, 16'h0,    0, 16'hFEFF, 0);
    add(0, 1, 0, 0, 16'h0,    0,   4, 0, 16'h0,    0, 0, 16'h0,    1, 16'hFEFE, 0); // EXEC stall
    add(0, 1, 1, 0, 16'h0,    0,   4, 0, 16'h0,    0, 0, 16'h0,    0, 16'hFEFE, 0); // valid only once
    add(0, 0, 1, 0, 16'h0,    0,   2, 1, 16'h0102, 0, 0, 16'h0,    0, 16'hFEFE, 0); // FETCH 0102
    add(0, 0, 1, 0, 16'h0,    0,   3, 1, 16'h0102, 0, 0, 16'h0,    0, 16'hFEFE, 0); // WAIT no ack
    add(0, 1, 1, 0, 16'h0,    0,   3, 1, 16'h0102, 0, 1, 16'h0,    0, 16'hFEFE, 0);
    add(0, 1, 1, 0, 16'h0,    1,   4, 0, 16'h0,    0, 0, 16'h0,    1, 16'hFEFD, 0); // halt, PC=0103
    for (int k = 0; k < 10; k++)
      add(0, 1, 1, 0, 16'h0,  0,   5, 0, 16'h0,    0, 0, 16'h0,    0, 16'hFEFD, 1); // HALT idle
    add(1, 1, 1, 0, 16'h0,    0,   5, 0, 16'h0,    0, 0, 16'h0,    0, 16'hFEFD, 1); // resume
    add(0, 1, 1, 0, 16'h0,    0,   2, 1, 16'h0103, 0, 0, 16'h0,    0, 16'hFEFD, 0); // FETCH 0103
    add(0, 1, 1, 0, 16'h0,    0,   3, 1, 16'h0103, 0, 1, 16'h0,    0, 16'hFEFD, 0);
    add(0, 1, 1, 1, 16'h2000, 0,   4, 0, 16'h0,    1, 0, 16'h2000, 1, 16'hFEFC, 0); // branch
    add(0, 1, 0, 0, 16'h0,    0,   2, 1, 16'h2000, 0, 0, 16'h0,    0, 16'hFEFC, 0); // FETCH 2000
    add(0, 1, 0, 0, 16'h0,    0,   3, 1, 16'h2000, 0, 1, 16'h0,    0, 16'hFEFC, 0);
    add(1, 0, 0, 1, 16'h3000, 0,   4, 0, 16'h0,    0, 0, 16'h0,    1, 16'hDFFF, 0); // no exec_done
    add(0, 0, 0, 0, 16'h0,    0,   4, 0, 16'h0,    0, 0, 16'h0,    0, 16'hDFFF, 0);

    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // ---- u0: table-driven sequence with instruction scoreboard ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      run[0] = vecs[i].run; mem_ack[0] = vecs[i].ack; exec_done[0] = vecs[i].ex;
      branch_taken[0] = vecs[i].br; branch_target = vecs[i].tgt; halt_req[0] = vecs[i].hlt;
      #1;
      check($sformatf("vec%0d", i),
            {8'h0, state[0], mem_rd[0], mem_addr[0], pc_load[0], pc_inc[0], pc_data[0],
             instr_valid[0], instr[0], halted[0]},
            {8'h0, vecs[i].st, vecs[i].rd, vecs[i].addr, vecs[i].ld, vecs[i].inc,
             vecs[i].pdata, vecs[i].iv, vecs[i].ins, vecs[i].hl});
      if (instr_valid[0]) begin
        if (sb.size() == 0) check("sb_unexpected_valid", 64'(instr[0]), 64'hFFFF_FFFF);
        else begin
          exp_ins = sb.pop_front();
          check("sb_instr", 64'(instr[0]), 64'(exp_ins));
        end
      end
      if (vecs[i].st == 3'd3 && vecs[i].ack) sb.push_back(~vecs[i].addr);
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
    run[0] = 0; mem_ack[0] = 0; exec_done[0] = 0; branch_taken[0] = 0;

    // ---- u1: timeout after exactly 4 WAIT cycles, FAULT sticky ----
    @(negedge clk); run[1] = 1'b1; #1 check("to_idle", 64'(state[1]), 64'd0);
    @(negedge clk); run[1] = 1'b0; #1 check("to_vector", 64'(state[1]), 64'd1);
    @(negedge clk); #1 check("to_fetch", 64'(state[1]), 64'd2);
    for (int w = 1; w <= 4; w++) begin
      @(negedge clk); #1;
      check($sformatf("to_wait%0d", w), {62'(state[1]), fault[1], mem_rd[1]}, {62'd3, 1'b0, 1'b1});
    end
    @(negedge clk); #1;
    check("to_fault", {61'(state[1]), fault[1], mem_rd[1], pc_inc[1]}, {61'd6, 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); run[1] = k[0]; #1;
      check($sformatf("fault_sticky%0d", k), {61'(state[1]), fault[1], mem_rd[1], pc_load[1]},
            {61'd6, 1'b1, 1'b0, 1'b0});
    end
    run[1] = 1'b0;
    @(negedge clk); reset_n = 1'b0; #1;
    check("fault_cleared", {62'(state[1]), fault[1], halted[1]}, 64'd0);
    @(negedge clk); reset_n = 1'b1;

    // ---- u1: ack in the 4th WAIT cycle wins over the timeout ----
    @(negedge clk); run[1] = 1'b1;
    @(negedge clk); run[1] = 1'b0;
    @(negedge clk); #1 check("bd_fetch", 64'(state[1]), 64'd2);
    for (int w = 1; w <= 3; w++) begin
      @(negedge clk); #1 check($sformatf("bd_wait%0d", w), 64'(state[1]), 64'd3);
    end
    @(negedge clk); mem_ack[1] = 1'b1; #1;
    check("bd_ack_inc", {62'(state[1]), pc_inc[1], pc_load[1]}, {62'd3, 1'b1, 1'b0});
    @(negedge clk); mem_ack[1] = 1'b0; #1;
    check("bd_exec", {44'(state[1]), fault[1], instr_valid[1], instr[1]}, {44'd4, 1'b0, 1'b1, 16'hFEFF});
    check("bd_pc", 64'(pc_value[1]), 64'h0101);

    // ---- u1: asynchronous reset in the middle of WAIT ----
    @(negedge clk); exec_done[1] = 1'b1;
    @(negedge clk); exec_done[1] = 1'b0; #1 check("rst_fetch", 64'(state[1]), 64'd2);
    @(negedge clk); mem_ack[1] = 1'b1; #1;
    check("rst_pre", {62'(state[1]), pc_inc[1], mem_rd[1]}, {62'd3, 1'b1, 1'b1});
    #1 reset_n = 1'b0;
    #1 check("rst_async", {39'(state[1]), mem_rd[1], mem_addr[1], pc_inc[1], instr_valid[1], instr[1]}, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("late_ack%0d", k),
            {42'(state[1]), mem_rd[1], pc_inc[1], instr_valid[1], pc_load[1], instr[1]}, 64'd0);
    end
    mem_ack[1] = 1'b0;

    // ---- u2: timeout disabled, 300-cycle wait never faults ----
    @(negedge clk); run[2] = 1'b1;
    @(negedge clk); run[2] = 1'b0; #1;
    check("dis_vector", {45'(state[2]), pc_load[2], pc_data[2]}, {45'd1, 1'b1, 16'h0000});
    @(negedge clk); #1 check("dis_fetch", 64'(state[2]), 64'd2);
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (state[2] !== 3'd3 || fault[2] !== 1'b0) bad++;
    end
    check("dis_no_fault", 64'(bad), 64'd0);
    mem_ack[2] = 1'b1;
    @(negedge clk); mem_ack[2] = 1'b0; #1;
    check("dis_exec", {47'(state[2]), instr_valid[2], instr[2]}, {47'd4, 1'b1, 16'hFFFF});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
